fetch_redirect_ctrl: RTL
========================

Name: fetch_redirect_ctrl

Overview:
Front-end fetch sequencer placed ahead of the PC register / I-cache index port. It arbitrates the three next-PC sources (CP0 exception, branch-mispredict flush, BTB prediction), then the sequential line. It sequences the extra delay-slot line fetch when a predicted-taken branch sits in the last word of a 16-byte line. It also holds the fetch stream on misaligned targets until a redirect arrives.

Parameters:
RESET_PC, 32'hBFC0_0000, first fetch address after reset
LINE_OFFSET_W, 4, byte-offset bits per fetch line (4 words)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active low (0 = reset)
stop_fetch_i  in  1  instruction queue full; suppress new requests
exc_occur_i  in  1  CP0 exception redirect pulse
exc_dest_i  in  32  exception target
flush_i  in  1  branch-mispredict redirect pulse
flush_dest_i  in  32  corrected target
pred_taken_i  in  1  BTB predicts taken for the current fetch line
pred_pc_i  in  32  predicted target
pred_ds_next_line_i  in  1  predicted branch is in word 3; delay slot lies in next line
index_ok_i  in  1  I-cache accepted the request this cycle
fetch_req_o  out  1  fetch request valid
fetch_pc_o  out  32  current fetch address (registered)
fetch_mask_o  out  4  instruction enable, bit i = word i of the line
fetch_adel_o  out  1  current fetch_pc misaligned (AdEL)
kill_o  out  1  one-cycle pulse: discard in-flight front-end data

Behaviour:
- Reset (rst=0, async): fetch_pc_o=RESET_PC, fetch_mask_o=4'b1111, fetch_adel_o=0, kill_o=0, state=RUN, saved target=0.
- fetch_req_o = rst && !stop_fetch_i && state!=ADEL_HALT. Combinational, no other dependence.
- accept = fetch_req_o && index_ok_i. Registers advance only on accept or on a redirect.
- Priority in one cycle: exc_occur_i > flush_i > (accept-based prediction/sequential). Redirects apply regardless of accept or stop_fetch_i.
- Redirect: next cycle fetch_pc_o=target, state=RUN, kill_o=1 for exactly that cycle.
  - fetch_mask_o from target[3:2]: 00→1111, 01→1110, 10→1100, 11→1000.
  - Discards any saved delay-slot target.
- RUN on accept:
  - pred_taken_i && !pred_ds_next_line_i → fetch_pc_o=pred_pc_i, mask per offset.
  - pred_taken_i && pred_ds_next_line_i → save pred_pc_i; fetch_pc_o = {pc[31:4]+1, 4'h0}; mask=4'b0001; state=DS_FETCH.
  - otherwise sequential: fetch_pc_o = {pc[31:4]+1, 4'h0}; mask=1111. Line increment wraps 32'hFFFF_FFF0→0.
- DS_FETCH on accept: fetch_pc_o=saved target, mask per offset, state=RUN. pred_* inputs are ignored in DS_FETCH.
- Misalignment: any new fetch_pc with [1:0]!=0 sets fetch_adel_o=1, mask=0000, state=ADEL_HALT. fetch_pc_o still carries the bad address for BadVAddr.
- ADEL_HALT: no requests; leaves only on exc_occur_i/flush_i (normal redirect, adel cleared).
- stop_fetch_i=1: registers hold, no accept. Redirects still latch.
- Reset asserted mid-operation: immediate return to reset values; fetch_req_o=0 while rst=0.

Optional Feature:
FETCH_REDIR_STAT_EN: adds 32-bit saturating counters and outputs stat_redirects_o (exc+flush events), stat_ds_fetches_o (DS_FETCH entries), stat_stall_cycles_o (cycles with rst && stop_fetch_i). Counters reset to 0. Without the macro these ports and counters do not exist; functional behaviour is identical.

Decomposition:
Shared package/defines: state encoding (RUN=2'd0, DS_FETCH=2'd1, ADEL_HALT=2'd2), RESET_PC default, mask constants, AdEL code constant. Natural sub-module: fetch_mask_gen (combinational target[3:2] → 4-bit mask), also reusable by the PC register.

Test Plan:
- Reset release, index_ok_i=1 every cycle → fetch_pc_o BFC00000, BFC00010, BFC00020; mask 1111; kill_o=0.
- In RUN at pc=BFC00010, pred_taken_i=1, pred_pc_i=BFC00108, pred_ds_next_line_i=1, accept → next BFC00020 mask 0001 (DS_FETCH); accept → BFC00108 mask 1100, state RUN.
- exc_occur_i and flush_i in the same cycle with stop_fetch_i=1, dests BFC00380 / 80001000 → next cycle fetch_pc_o=BFC00380, mask 1111, kill_o=1 for one cycle only.
- flush_i with flush_dest_i=80000006 → fetch_adel_o=1, mask 0000, fetch_req_o=0 for 10 cycles; then exc_occur_i to BFC00380 → adel cleared, requests resume.
- index_ok_i=0 for 5 cycles in DS_FETCH, then flush_i to 80002004 → saved target dropped, fetch_pc_o=80002004, mask 1110.
- Sequential at pc=FFFFFFF0, accept → fetch_pc_o=00000000, mask 1111.

Source files
------------

// File: rtl/fetch_redirect_ctrl_pkg.sv
// Shared definitions for the fetch redirect controller: FSM encoding,
// reset fetch address, fetch-line mask constants and the AdEL exception code.
package fetch_redirect_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_DS_FETCH  = 2'd1,
        ST_ADEL_HALT = 2'd2
    } fetch_state_e;

    // CP0 exception code reported for an instruction-fetch address error
    typedef enum logic [4:0] {
        EXC_CODE_ADEL = 5'h04
    } exc_code_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;

    localparam logic [3:0] MASK_FULL    = 4'b1111;
    localparam logic [3:0] MASK_DS_ONLY = 4'b0001;
    localparam logic [3:0] MASK_NONE    = 4'b0000;

    // Instruction fetches must be word aligned
    function automatic logic is_misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/fetch_redirect_ctrl_mask_gen.sv
// Instruction-enable mask for a fetch line: words below the entry word of a
// jump target are disabled; a misaligned target enables nothing.
module fetch_redirect_ctrl_mask_gen
    import fetch_redirect_ctrl_pkg::*;
(
    input  logic [1:0] word_i,
    input  logic       adel_i,
    output logic [3:0] mask_o
);

    // Decode the entry word into a thermometer mask
    always_comb begin
        // NOTE: every path assigns mask_o, so no latch is inferred.
        mask_o = MASK_FULL;
        if (adel_i) begin
            mask_o = MASK_NONE;
        end else begin
            unique case (word_i)
                2'b00:   mask_o = 4'b1111;
                2'b01:   mask_o = 4'b1110;
                2'b10:   mask_o = 4'b1100;
                default: mask_o = 4'b1000;
            endcase
        end
    end

endmodule

// File: rtl/fetch_redirect_ctrl.sv
// Fetch sequencer ahead of the PC register / I-cache index port. Arbitrates
// exception, mispredict flush, BTB prediction and sequential next-PC, inserts
// the extra delay-slot line fetch, and halts on misaligned targets.
// Optional statistics counters are built when FETCH_REDIR_STAT_EN is defined.
module fetch_redirect_ctrl
    import fetch_redirect_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC      = RESET_PC_DEFAULT,
    parameter int          LINE_OFFSET_W = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stop_fetch_i,
    input  logic        exc_occur_i,
    input  logic [31:0] exc_dest_i,
    input  logic        flush_i,
    input  logic [31:0] flush_dest_i,
    input  logic        pred_taken_i,
    input  logic [31:0] pred_pc_i,
    input  logic        pred_ds_next_line_i,
    input  logic        index_ok_i,
`ifdef FETCH_REDIR_STAT_EN
    output logic [31:0] stat_redirects_o,
    output logic [31:0] stat_ds_fetches_o,
    output logic [31:0] stat_stall_cycles_o,
`endif
    output logic        fetch_req_o,
    output logic [31:0] fetch_pc_o,
    output logic [3:0]  fetch_mask_o,
    output logic        fetch_adel_o,
    output logic        kill_o
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [3:0]   mask_q, mask_d;
    logic         adel_q, adel_d;
    logic         kill_q, kill_d;
    logic [31:0]  saved_q, saved_d;

    logic         redirect;
    logic         accept;
    logic [31:0]  load_target;
    logic         load_adel;
    logic [3:0]   load_mask;
    logic [31:0]  seq_pc;

    assign redirect = exc_occur_i | flush_i;
    assign accept   = fetch_req_o & index_ok_i;
    assign seq_pc   = ((pc_q >> LINE_OFFSET_W) + 32'd1) << LINE_OFFSET_W;

    // Select the non-sequential target in priority order
    always_comb begin
        if (exc_occur_i)                load_target = exc_dest_i;
        else if (flush_i)               load_target = flush_dest_i;
        else if (state_q == ST_DS_FETCH) load_target = saved_q;
        else                            load_target = pred_pc_i;
    end

    assign load_adel = is_misaligned(load_target);

    fetch_redirect_ctrl_mask_gen u_mask_gen (
        .word_i (load_target[3:2]),
        .adel_i (load_adel),
        .mask_o (load_mask)
    );

    // State and fetch-address registers
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!rst) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_PC;
            mask_q  <= MASK_FULL;
            adel_q  <= 1'b0;
            kill_q  <= 1'b0;
            saved_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            mask_q  <= mask_d;
            adel_q  <= adel_d;
            kill_q  <= kill_d;
            saved_q <= saved_d;
        end
    end

    // Next-state: redirect beats prediction, prediction beats sequential
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        mask_d  = mask_q;
        adel_d  = adel_q;
        kill_d  = 1'b0;
        saved_d = saved_q;

        if (redirect) begin
            pc_d    = load_target;
            mask_d  = load_mask;
            adel_d  = load_adel;
            state_d = load_adel ? ST_ADEL_HALT : ST_RUN;
            kill_d  = 1'b1;
            saved_d = '0;
        end else if (accept) begin
            unique case (state_q)
                ST_RUN: begin
                    if (pred_taken_i && pred_ds_next_line_i) begin
                        // Fetch the delay-slot line first, jump afterwards
                        saved_d = pred_pc_i;
                        pc_d    = seq_pc;
                        mask_d  = MASK_DS_ONLY;
                        adel_d  = 1'b0;
                        state_d = ST_DS_FETCH;
                    end else if (pred_taken_i) begin
                        pc_d    = load_target;
                        mask_d  = load_mask;
                        adel_d  = load_adel;
                        state_d = load_adel ? ST_ADEL_HALT : ST_RUN;
                    end else begin
                        pc_d    = seq_pc;
                        mask_d  = MASK_FULL;
                        adel_d  = 1'b0;
                    end
                end
                ST_DS_FETCH: begin
                    pc_d    = load_target;
                    mask_d  = load_mask;
                    adel_d  = load_adel;
                    state_d = load_adel ? ST_ADEL_HALT : ST_RUN;
                    saved_d = '0;
                end
                default: ;
            endcase
        end
    end

    // Outputs: request is combinational, the rest come straight from registers
    always_comb begin
        fetch_req_o  = rst && !stop_fetch_i && (state_q != ST_ADEL_HALT);
        fetch_pc_o   = pc_q;
        fetch_mask_o = mask_q;
        fetch_adel_o = adel_q;
        kill_o       = kill_q;
    end

`ifdef FETCH_REDIR_STAT_EN
    logic ds_entry;
    assign ds_entry = !redirect && accept && (state_q == ST_RUN)
                      && pred_taken_i && pred_ds_next_line_i;

    // Saturating event counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_redirects_o    <= '0;
            stat_ds_fetches_o   <= '0;
            stat_stall_cycles_o <= '0;
        end else begin
            if (redirect && (stat_redirects_o != '1))
                stat_redirects_o <= stat_redirects_o + 32'd1;
            if (ds_entry && (stat_ds_fetches_o != '1))
                stat_ds_fetches_o <= stat_ds_fetches_o + 32'd1;
            if (stop_fetch_i && (stat_stall_cycles_o != '1))
                stat_stall_cycles_o <= stat_stall_cycles_o + 32'd1;
        end
    end
`endif

endmodule
